// File: rtl/ysyx_25030093_wbu.sv
// Writeback unit: LSU-over-EXU arbitration onto the register file write port plus a pending-write scoreboard.
// Optional same-cycle operand bypass is enabled with `define YSYX_25030093_WBU_BYPASS_EN.
module ysyx_25030093_wbu #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
`ifdef YSYX_25030093_WBU_BYPASS_EN
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
`endif
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic                  lsu_fire;
  logic                  exu_fire;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  // Fixed priority: a valid LSU result always blocks the EXU
  assign lsu_ready = !rst;
  assign exu_ready = !rst && !lsu_valid;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign exu_fire  = exu_valid && exu_ready;

  always_comb begin
    win_rd   = exu_rd;
    win_data = exu_data;
    if (lsu_valid) begin
      win_rd   = lsu_rd;
      win_data = lsu_data;
    end
  end

  // Clear on writeback first so a same-edge issue to that register wins
  always_comb begin
    pend_nxt = pend;
    if (rf_wen) begin
      pend_nxt[rf_waddr] = 1'b0;
    end
    if (issue_valid) begin
      pend_nxt[issue_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pend     <= '0;
    end else begin
      pend   <= pend_nxt;
      rf_wen <= (lsu_fire || exu_fire) && (win_rd != '0);
      if (lsu_fire || exu_fire) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

`ifdef YSYX_25030093_WBU_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rf_wen && (rf_waddr == rs1_addr) && (rs1_addr != '0);
  assign rs2_hit  = rf_wen && (rf_waddr == rs2_addr) && (rs2_addr != '0);
  assign rs1_fwd  = rs1_hit;
  assign rs2_fwd  = rs2_hit;
  assign rs1_busy = pend[rs1_addr] && !rs1_hit;
  assign rs2_busy = pend[rs2_addr] && !rs2_hit;
`else
  assign rs1_busy = pend[rs1_addr];
  assign rs2_busy = pend[rs2_addr];
`endif

endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Bench for ysyx_25030093_wbu: expected writebacks queued at handshake time, matched on the falling edge.
module tb_ysyx_25030093_wbu;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        exu_valid = 1'b0;
  logic        exu_ready;
  logic [4:0]  exu_rd = '0;
  logic [31:0] exu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy;
  logic        rs2_busy;
`ifdef YSYX_25030093_WBU_BYPASS_EN
  logic        rs1_fwd;
  logic        rs2_fwd;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  bit          done = 1'b0;
  exp_t        exp_q[$];

  ysyx_25030093_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
`ifdef YSYX_25030093_WBU_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
`endif
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every cycle: rf_wen must match whether a write is due now, and due writes must match the queue head
  always @(negedge clk) begin
    if (!done) begin
      automatic bit due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("rf_wen", 64'(rf_wen), 64'(due));
      if (due) begin
        automatic exp_t e = exp_q.pop_front();
        check("rf_waddr", 64'(rf_waddr), 64'(e.rd));
        check("rf_wdata", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lsu_valid   = 1'b0;
    exu_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  // Drive both producers for one cycle; the model predicts the winner and the resulting write
  task automatic xfer(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic ev, input logic [4:0] erd, input logic [31:0] ed);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    #1;
    check("lsu_ready", 64'(lsu_ready), 64'(1));
    check("exu_ready", 64'(exu_ready), 64'(!lv));
    if (lv && lrd != 5'd0)
      exp_q.push_back('{cyc: cyc + 1, rd: lrd, data: ld});
    else if (!lv && ev && erd != 5'd0)
      exp_q.push_back('{cyc: cyc + 1, rd: erd, data: ed});
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset: readies low, outputs and scoreboard cleared
    exu_valid = 1'b1;
    lsu_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_lsu_ready", 64'(lsu_ready), 64'(0));
    check("rst_exu_ready", 64'(exu_ready), 64'(0));
    check("rst_waddr", 64'(rf_waddr), 64'(0));
    check("rst_wdata", 64'(rf_wdata), 64'(0));
    rs1_addr = 5'd7; rs2_addr = 5'd31; #1;
    check("rst_rs1_busy", 64'(rs1_busy), 64'(0));
    check("rst_rs2_busy", 64'(rs2_busy), 64'(0));
    exu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single EXU write
    xfer(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    idle(2);

    // Simultaneous valid: LSU then EXU on consecutive cycles
    xfer(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
    xfer(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hBB);
    idle(2);

    // Scoreboard set, hold and release through an LSU write
    issue(5'd7);
    step();
    rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
    check("sb_busy_set", 64'(rs1_busy), 64'(1));
    step();
    check("sb_busy_hold", 64'(rs2_busy), 64'(1));
    xfer(1'b1, 5'd7, 32'hCAFE_0007, 1'b0, 5'd0, 32'h0);
`ifdef YSYX_25030093_WBU_BYPASS_EN
    check("sb_busy_wen_cycle", 64'(rs1_busy), 64'(0));
    check("sb_fwd_wen_cycle", 64'(rs1_fwd), 64'(1));
    check("sb_fwd2_wen_cycle", 64'(rs2_fwd), 64'(1));
`else
    check("sb_busy_wen_cycle", 64'(rs1_busy), 64'(1));
`endif
    step();
    check("sb_busy_cleared", 64'(rs1_busy), 64'(0));
    check("sb_busy2_cleared", 64'(rs2_busy), 64'(0));

    // x0: handshake completes without a write, issue to x0 leaves it idle
    xfer(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    issue(5'd0);
    rs1_addr = 5'd0;
    step();
    check("x0_busy", 64'(rs1_busy), 64'(0));
    idle(1);

    // Set/clear collision on reg 9: the set wins
    issue(5'd9);
    step();
    xfer(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    issue(5'd9);
    rs2_addr = 5'd9;
    step();
    check("collide_busy", 64'(rs2_busy), 64'(1));
    step();
    check("collide_busy_hold", 64'(rs2_busy), 64'(1));

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      automatic logic        lv  = 1'($urandom_range(0, 1));
      automatic logic        ev  = 1'($urandom_range(0, 1));
      automatic logic [4:0]  lrd = 5'($urandom_range(0, 31));
      automatic logic [4:0]  erd = 5'($urandom_range(0, 31));
      automatic logic [31:0] ld  = $urandom;
      automatic logic [31:0] ed  = $urandom;
      xfer(lv, lrd, ld, ev, erd, ed);
    end
    idle(2);

    // Reset mid-operation discards the held write and clears the scoreboard
    issue(5'd13);
    step();
    xfer(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1212);
    rst = 1'b1;
    exu_valid = 1'b1;
    #1;
    check("midrst_exu_ready", 64'(exu_ready), 64'(0));
    check("midrst_lsu_ready", 64'(lsu_ready), 64'(0));
    step();
    rst = 1'b0;
    rs1_addr = 5'd9; rs2_addr = 5'd13; #1;
    check("midrst_rf_wen", 64'(rf_wen), 64'(0));
    check("midrst_busy9", 64'(rs1_busy), 64'(0));
    check("midrst_busy13", 64'(rs2_busy), 64'(0));
    idle(2);

    check("drain", 64'(exp_q.size()), 64'(0));
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
